// File: rtl/sram_arb_pkg.sv
// ============================================================================
//  Module      : sram_arb_pkg
//  Description : Shared types and helpers for the two-port SRAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_arb_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_e;

    localparam int unsigned SRAM_ARB_ADDR_WIDTH = 32;
    localparam int unsigned SRAM_ARB_DATA_WIDTH = 64;
    localparam int unsigned SRAM_ARB_STRB_WIDTH = SRAM_ARB_DATA_WIDTH >> 3;

    // Reference layouts at the default widths; the top re-declares them at its own widths.
    typedef struct packed {
        logic                           we;
        logic [SRAM_ARB_ADDR_WIDTH-1:0] addr;
        logic [SRAM_ARB_DATA_WIDTH-1:0] wdata;
        logic [SRAM_ARB_STRB_WIDTH-1:0] strb;
    } sram_req_t;

    typedef struct packed {
        logic                           rvalid;
        logic [SRAM_ARB_DATA_WIDTH-1:0] rdata;
    } sram_rsp_t;

    function automatic port_id_e other_port(input port_id_e id);
        return (id == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_arb_rr.sv
// ============================================================================
//  Module      : sram_arb_rr
//  Description : Two-way round-robin grant with a hold-lock for port B.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_a_req,
    input  logic i_b_req,
    input  logic i_b_lock,
    output logic o_a_gnt,
    output logic o_b_gnt
);

    port_id_e r_last;
    logic     r_lock;
    logic     w_b_wins;

    // B wins when alone, when holding the lock, or when it is B's round-robin turn.
    assign w_b_wins = i_b_req & (~i_a_req | r_lock | (other_port(r_last) == PORT_B));
    assign o_b_gnt  = w_b_wins;
    assign o_a_gnt  = i_a_req & ~w_b_wins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT_B;
            r_lock <= 1'b0;
        end else begin
            r_lock <= o_b_gnt & i_b_lock;
            if (o_a_gnt | o_b_gnt) begin
                r_last <= o_b_gnt ? PORT_B : PORT_A;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ============================================================================
//  Module      : sram_port_arbiter
//  Description : Shares one 1-cycle-latency SRAM between a core port (A) and a
//                loader/debug port (B). Taint tracking is compiled in when the
//                macro SRAM_ARB_TAINT_EN is defined; otherwise _t0 outputs are 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned StrbWidth = DataWidth >> 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // port A
    input  logic                 a_req_i,
    input  logic                 a_we_i,
    input  logic [AddrWidth-1:0] a_addr_i,
    input  logic [DataWidth-1:0] a_wdata_i,
    input  logic [StrbWidth-1:0] a_strb_i,
    output logic                 a_gnt_o,
    output logic                 a_rvalid_o,
    output logic [DataWidth-1:0] a_rdata_o,
    input  logic                 a_req_i_t0,
    input  logic                 a_we_i_t0,
    input  logic [AddrWidth-1:0] a_addr_i_t0,
    input  logic [DataWidth-1:0] a_wdata_i_t0,
    input  logic [StrbWidth-1:0] a_strb_i_t0,
    output logic                 a_gnt_o_t0,
    output logic                 a_rvalid_o_t0,
    output logic [DataWidth-1:0] a_rdata_o_t0,
    // port B
    input  logic                 b_req_i,
    input  logic                 b_we_i,
    input  logic [AddrWidth-1:0] b_addr_i,
    input  logic [DataWidth-1:0] b_wdata_i,
    input  logic [StrbWidth-1:0] b_strb_i,
    input  logic                 b_lock_i,
    output logic                 b_gnt_o,
    output logic                 b_rvalid_o,
    output logic [DataWidth-1:0] b_rdata_o,
    input  logic                 b_req_i_t0,
    input  logic                 b_we_i_t0,
    input  logic [AddrWidth-1:0] b_addr_i_t0,
    input  logic [DataWidth-1:0] b_wdata_i_t0,
    input  logic [StrbWidth-1:0] b_strb_i_t0,
    input  logic                 b_lock_i_t0,
    output logic                 b_gnt_o_t0,
    output logic                 b_rvalid_o_t0,
    output logic [DataWidth-1:0] b_rdata_o_t0,
    // shared SRAM
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [StrbWidth-1:0] sram_strb_o,
    input  logic [DataWidth-1:0] sram_rdata_i,
    output logic                 sram_req_o_t0,
    output logic                 sram_we_o_t0,
    output logic [AddrWidth-1:0] sram_addr_o_t0,
    output logic [DataWidth-1:0] sram_wdata_o_t0,
    output logic [StrbWidth-1:0] sram_strb_o_t0,
    input  logic [DataWidth-1:0] sram_rdata_i_t0
);

    typedef struct packed {
        logic                 we;
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] strb;
    } port_req_t;

    logic      w_a_gnt;
    logic      w_b_gnt;
    port_id_e  w_winner;
    port_req_t w_a_fields;
    port_req_t w_b_fields;
    port_req_t w_sel;
    logic      r_rsp_valid;
    port_id_e  r_rsp_owner;
    logic      w_unused_t0;

    sram_arb_rr u_rr (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .i_a_req  (a_req_i),
        .i_b_req  (b_req_i),
        .i_b_lock (b_lock_i),
        .o_a_gnt  (w_a_gnt),
        .o_b_gnt  (w_b_gnt)
    );

    assign a_gnt_o    = w_a_gnt;
    assign b_gnt_o    = w_b_gnt;
    assign w_winner   = w_b_gnt ? PORT_B : PORT_A;
    assign sram_req_o = a_req_i | b_req_i;

    assign w_a_fields = '{we: a_we_i, addr: a_addr_i, wdata: a_wdata_i, strb: a_strb_i};
    assign w_b_fields = '{we: b_we_i, addr: b_addr_i, wdata: b_wdata_i, strb: b_strb_i};

    // Idle bus is driven to zero so nothing leaks out while no one is requesting.
    always_comb begin
        w_sel = '0;
        if (sram_req_o) begin
            w_sel = w_b_gnt ? w_b_fields : w_a_fields;
        end
    end

    assign sram_we_o    = w_sel.we;
    assign sram_addr_o  = w_sel.addr;
    assign sram_wdata_o = w_sel.wdata;
    assign sram_strb_o  = w_sel.strb;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_owner <= PORT_A;
        end else begin
            r_rsp_valid <= sram_req_o;
            r_rsp_owner <= w_winner;
        end
    end

    assign a_rvalid_o = r_rsp_valid & (r_rsp_owner == PORT_A);
    assign b_rvalid_o = r_rsp_valid & (r_rsp_owner == PORT_B);
    assign a_rdata_o  = a_rvalid_o ? sram_rdata_i : '0;
    assign b_rdata_o  = b_rvalid_o ? sram_rdata_i : '0;

`ifdef SRAM_ARB_TAINT_EN
    port_req_t w_a_t0;
    port_req_t w_b_t0;
    port_req_t w_sel_t0;
    logic      w_both_req;
    logic      r_a_rvalid_t0;
    logic      r_b_rvalid_t0;

    assign w_a_t0 = '{we: a_we_i_t0, addr: a_addr_i_t0, wdata: a_wdata_i_t0, strb: a_strb_i_t0};
    assign w_b_t0 = '{we: b_we_i_t0, addr: b_addr_i_t0, wdata: b_wdata_i_t0, strb: b_strb_i_t0};

    always_comb begin
        w_sel_t0 = '0;
        if (sram_req_o) begin
            w_sel_t0 = w_b_gnt ? w_b_t0 : w_a_t0;
        end
    end

    assign sram_req_o_t0   = w_b_gnt ? b_req_i_t0 : a_req_i_t0;
    assign sram_we_o_t0    = w_sel_t0.we;
    assign sram_addr_o_t0  = w_sel_t0.addr;
    assign sram_wdata_o_t0 = w_sel_t0.wdata;
    assign sram_strb_o_t0  = w_sel_t0.strb;

    // Under contention either request's taint can flip who gets the grant.
    assign w_both_req = a_req_i & b_req_i;
    assign a_gnt_o_t0 = w_both_req ? (a_req_i_t0 | b_req_i_t0) : a_req_i_t0;
    assign b_gnt_o_t0 = w_both_req ? (a_req_i_t0 | b_req_i_t0) : b_req_i_t0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a_rvalid_t0 <= 1'b0;
            r_b_rvalid_t0 <= 1'b0;
        end else begin
            r_a_rvalid_t0 <= a_gnt_o_t0;
            r_b_rvalid_t0 <= b_gnt_o_t0;
        end
    end

    assign a_rvalid_o_t0 = r_a_rvalid_t0;
    assign b_rvalid_o_t0 = r_b_rvalid_t0;
    assign a_rdata_o_t0  = a_rvalid_o ? sram_rdata_i_t0 : '0;
    assign b_rdata_o_t0  = b_rvalid_o ? sram_rdata_i_t0 : '0;
    assign w_unused_t0   = b_lock_i_t0;
`else
    assign sram_req_o_t0   = 1'b0;
    assign sram_we_o_t0    = 1'b0;
    assign sram_addr_o_t0  = '0;
    assign sram_wdata_o_t0 = '0;
    assign sram_strb_o_t0  = '0;
    assign a_gnt_o_t0      = 1'b0;
    assign b_gnt_o_t0      = 1'b0;
    assign a_rvalid_o_t0   = 1'b0;
    assign b_rvalid_o_t0   = 1'b0;
    assign a_rdata_o_t0    = '0;
    assign b_rdata_o_t0    = '0;
    assign w_unused_t0     = ^{a_req_i_t0, a_we_i_t0, a_addr_i_t0, a_wdata_i_t0, a_strb_i_t0,
                               b_req_i_t0, b_we_i_t0, b_addr_i_t0, b_wdata_i_t0, b_strb_i_t0,
                               b_lock_i_t0, sram_rdata_i_t0};
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
//  Module      : tb_sram_port_arbiter
//  Description : Directed self-checking bench for sram_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = 8;
`ifdef SRAM_ARB_TAINT_EN
    localparam bit TAINT = 1'b1;
`else
    localparam bit TAINT = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          a_req_i, a_we_i, a_gnt_o, a_rvalid_o;
    logic [AW-1:0] a_addr_i;
    logic [DW-1:0] a_wdata_i, a_rdata_o;
    logic [SW-1:0] a_strb_i;
    logic          a_req_i_t0, a_we_i_t0, a_gnt_o_t0, a_rvalid_o_t0;
    logic [AW-1:0] a_addr_i_t0;
    logic [DW-1:0] a_wdata_i_t0, a_rdata_o_t0;
    logic [SW-1:0] a_strb_i_t0;
    logic          b_req_i, b_we_i, b_lock_i, b_gnt_o, b_rvalid_o;
    logic [AW-1:0] b_addr_i;
    logic [DW-1:0] b_wdata_i, b_rdata_o;
    logic [SW-1:0] b_strb_i;
    logic          b_req_i_t0, b_we_i_t0, b_lock_i_t0, b_gnt_o_t0, b_rvalid_o_t0;
    logic [AW-1:0] b_addr_i_t0;
    logic [DW-1:0] b_wdata_i_t0, b_rdata_o_t0;
    logic [SW-1:0] b_strb_i_t0;
    logic          sram_req_o, sram_we_o, sram_req_o_t0, sram_we_o_t0;
    logic [AW-1:0] sram_addr_o, sram_addr_o_t0;
    logic [DW-1:0] sram_wdata_o, sram_wdata_o_t0, sram_rdata_i, sram_rdata_i_t0;
    logic [SW-1:0] sram_strb_o, sram_strb_o_t0;

    int n_checks = 0;
    int n_fail   = 0;

    sram_port_arbiter #(.AddrWidth(AW), .DataWidth(DW), .StrbWidth(SW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .a_req_i(a_req_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
        .a_strb_i(a_strb_i), .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o),
        .a_req_i_t0(a_req_i_t0), .a_we_i_t0(a_we_i_t0), .a_addr_i_t0(a_addr_i_t0),
        .a_wdata_i_t0(a_wdata_i_t0), .a_strb_i_t0(a_strb_i_t0), .a_gnt_o_t0(a_gnt_o_t0),
        .a_rvalid_o_t0(a_rvalid_o_t0), .a_rdata_o_t0(a_rdata_o_t0),
        .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
        .b_strb_i(b_strb_i), .b_lock_i(b_lock_i), .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o),
        .b_rdata_o(b_rdata_o),
        .b_req_i_t0(b_req_i_t0), .b_we_i_t0(b_we_i_t0), .b_addr_i_t0(b_addr_i_t0),
        .b_wdata_i_t0(b_wdata_i_t0), .b_strb_i_t0(b_strb_i_t0), .b_lock_i_t0(b_lock_i_t0),
        .b_gnt_o_t0(b_gnt_o_t0), .b_rvalid_o_t0(b_rvalid_o_t0), .b_rdata_o_t0(b_rdata_o_t0),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_strb_o(sram_strb_o), .sram_rdata_i(sram_rdata_i),
        .sram_req_o_t0(sram_req_o_t0), .sram_we_o_t0(sram_we_o_t0),
        .sram_addr_o_t0(sram_addr_o_t0), .sram_wdata_o_t0(sram_wdata_o_t0),
        .sram_strb_o_t0(sram_strb_o_t0), .sram_rdata_i_t0(sram_rdata_i_t0)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive_idle();
        a_req_i = 0; a_we_i = 0; a_addr_i = '0; a_wdata_i = '0; a_strb_i = '0;
        b_req_i = 0; b_we_i = 0; b_addr_i = '0; b_wdata_i = '0; b_strb_i = '0; b_lock_i = 0;
        a_req_i_t0 = 0; a_we_i_t0 = 0; a_addr_i_t0 = '0; a_wdata_i_t0 = '0; a_strb_i_t0 = '0;
        b_req_i_t0 = 0; b_we_i_t0 = 0; b_addr_i_t0 = '0; b_wdata_i_t0 = '0; b_strb_i_t0 = '0;
        b_lock_i_t0 = 0; sram_rdata_i = '0; sram_rdata_i_t0 = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_ni = 1'b0;
        a_addr_i = 32'h1234_5678; a_wdata_i = 64'hFFFF_0000_FFFF_0000; sram_rdata_i = 64'h5A5A;
        #3;
        n_checks++;
        if ({a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, sram_req_o, sram_we_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, sram_req_o, sram_we_o});
        end
        n_checks++;
        if ({sram_addr_o, sram_wdata_o, sram_strb_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr %h wdata %h strb %h want 0",
                     sram_addr_o, sram_wdata_o, sram_strb_o);
        end
        n_checks++;
        if ({a_rdata_o, b_rdata_o} !== '0) begin
            n_fail++; $display("FAIL reset_rdata: got %h %h want 0", a_rdata_o, b_rdata_o);
        end
        @(negedge clk_i);
        drive_idle();
        rst_ni = 1'b1;
    endtask

    task automatic test_single_read();
        @(posedge clk_i); #1;
        a_req_i = 1; a_we_i = 0; a_addr_i = 32'h8000_0008; a_strb_i = 8'hFF;
        @(negedge clk_i);
        n_checks++;
        if ({a_gnt_o, b_gnt_o, sram_req_o, sram_we_o} !== 4'b1010) begin
            n_fail++;
            $display("FAIL read_gnt: got %b want 1010", {a_gnt_o, b_gnt_o, sram_req_o, sram_we_o});
        end
        n_checks++;
        if (sram_addr_o !== 32'h8000_0008) begin
            n_fail++; $display("FAIL read_addr: got %h want 80000008", sram_addr_o);
        end
        @(posedge clk_i); #1;
        a_req_i = 0; sram_rdata_i = 64'h0123_4567_89AB_CDEF;
        @(negedge clk_i);
        n_checks++;
        if ({a_rvalid_o, b_rvalid_o, a_gnt_o} !== 3'b100) begin
            n_fail++; $display("FAIL read_rvalid: got %b want 100", {a_rvalid_o, b_rvalid_o, a_gnt_o});
        end
        n_checks++;
        if (a_rdata_o !== 64'h0123_4567_89AB_CDEF || b_rdata_o !== '0) begin
            n_fail++; $display("FAIL read_rdata: got a %h b %h want a 0123456789abcdef b 0", a_rdata_o, b_rdata_o);
        end
        drive_idle();
    endtask

    task automatic test_write_b();
        @(posedge clk_i); #1;
        b_req_i = 1; b_we_i = 1; b_addr_i = 32'h0000_0100;
        b_wdata_i = 64'hCAFE_F00D_5555_AAAA; b_strb_i = 8'h0F;
        @(negedge clk_i);
        n_checks++;
        if ({a_gnt_o, b_gnt_o, sram_req_o, sram_we_o} !== 4'b0111) begin
            n_fail++; $display("FAIL write_gnt: got %b want 0111", {a_gnt_o, b_gnt_o, sram_req_o, sram_we_o});
        end
        n_checks++;
        if (sram_addr_o !== 32'h100 || sram_wdata_o !== 64'hCAFE_F00D_5555_AAAA || sram_strb_o !== 8'h0F) begin
            n_fail++;
            $display("FAIL write_bus: got %h %h %h want 00000100 cafef00d5555aaaa 0f",
                     sram_addr_o, sram_wdata_o, sram_strb_o);
        end
        @(posedge clk_i); #1;
        drive_idle();
        @(negedge clk_i);
        n_checks++;
        if ({a_rvalid_o, b_rvalid_o, sram_req_o} !== 3'b010) begin
            n_fail++; $display("FAIL write_rvalid: got %b want 010", {a_rvalid_o, b_rvalid_o, sram_req_o});
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_a;
        exp_a = 4'b0101;
        @(posedge clk_i); #1; rst_ni = 0;
        @(negedge clk_i); rst_ni = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            a_req_i = 1; b_req_i = 1; a_addr_i = 32'h1000; b_addr_i = 32'h2000;
            sram_rdata_i = 64'h100 + 64'(i);
            @(negedge clk_i);
            n_checks++;
            if (a_gnt_o !== exp_a[i] || b_gnt_o !== ~exp_a[i]) begin
                n_fail++; $display("FAIL rr_gnt[%0d]: got a%b b%b want a%b", i, a_gnt_o, b_gnt_o, exp_a[i]);
            end
            n_checks++;
            if (sram_addr_o !== (exp_a[i] ? 32'h1000 : 32'h2000)) begin
                n_fail++; $display("FAIL rr_addr[%0d]: got %h want %h", i, sram_addr_o,
                                   exp_a[i] ? 32'h1000 : 32'h2000);
            end
            if (i > 0) begin
                n_checks++;
                if (a_rvalid_o !== exp_a[i-1] || b_rvalid_o !== ~exp_a[i-1]) begin
                    n_fail++; $display("FAIL rr_rvalid[%0d]: got a%b b%b want a%b", i, a_rvalid_o,
                                       b_rvalid_o, exp_a[i-1]);
                end
                n_checks++;
                if ((a_rdata_o | b_rdata_o) !== 64'h100 + 64'(i)) begin
                    n_fail++; $display("FAIL rr_rdata[%0d]: got %h want %h", i, a_rdata_o | b_rdata_o,
                                       64'h100 + 64'(i));
                end
            end
        end
        @(posedge clk_i); #1;
        drive_idle();
        @(negedge clk_i);
        n_checks++;
        if ({a_rvalid_o, b_rvalid_o, sram_req_o} !== 3'b010) begin
            n_fail++; $display("FAIL rr_tail: got %b want 010", {a_rvalid_o, b_rvalid_o, sram_req_o});
        end
    endtask

    task automatic test_lock();
        logic [7:0] both, lock, exp_b, exp_a;
        both  = 8'b1011_1111;
        lock  = 8'b1110_0111;
        exp_b = 8'b0010_1110;
        exp_a = 8'b1001_0001;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            a_req_i = both[i]; b_req_i = both[i]; b_lock_i = lock[i];
            @(negedge clk_i);
            n_checks++;
            if (a_gnt_o !== exp_a[i] || b_gnt_o !== exp_b[i]) begin
                n_fail++; $display("FAIL lock_gnt[%0d]: got a%b b%b want a%b b%b", i, a_gnt_o, b_gnt_o,
                                   exp_a[i], exp_b[i]);
            end
        end
        @(posedge clk_i); #1;
        drive_idle();
    endtask

    task automatic test_reset_mid();
        @(posedge clk_i); #1;
        a_req_i = 1; a_addr_i = 32'h40;
        @(negedge clk_i);
        n_checks++;
        if (a_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_gnt: got %b want 1", a_gnt_o);
        end
        @(posedge clk_i); #1;
        a_req_i = 0; rst_ni = 0;
        #1;
        n_checks++;
        if ({a_rvalid_o, b_rvalid_o} !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_during: got %b want 00", {a_rvalid_o, b_rvalid_o});
        end
        @(negedge clk_i); rst_ni = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            n_checks++;
            if ({a_rvalid_o, b_rvalid_o} !== 2'b00) begin
                n_fail++; $display("FAIL rstmid_after[%0d]: got %b want 00", i, {a_rvalid_o, b_rvalid_o});
            end
        end
        @(posedge clk_i); #1;
        a_req_i = 1; b_req_i = 1;
        @(negedge clk_i);
        n_checks++;
        if ({a_gnt_o, b_gnt_o} !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_last: got %b want 10", {a_gnt_o, b_gnt_o});
        end
        @(posedge clk_i); #1;
        drive_idle();
    endtask

    task automatic test_taint();
        @(posedge clk_i); #1;
        a_req_i = 1; b_req_i = 1; a_req_i_t0 = 1; b_req_i_t0 = 0;
        a_addr_i = 32'h10; b_addr_i = 32'h20; a_addr_i_t0 = 32'hF0; b_addr_i_t0 = 32'h0F;
        @(negedge clk_i);
        n_checks++;
        if ({a_gnt_o, b_gnt_o} !== 2'b01) begin
            n_fail++; $display("FAIL taint_winner: got %b want 01", {a_gnt_o, b_gnt_o});
        end
        n_checks++;
        if ({a_gnt_o_t0, b_gnt_o_t0} !== {TAINT, TAINT}) begin
            n_fail++; $display("FAIL taint_gnt: got %b want %b", {a_gnt_o_t0, b_gnt_o_t0}, {TAINT, TAINT});
        end
        n_checks++;
        if (sram_addr_o_t0 !== (TAINT ? 32'h0F : 32'h0)) begin
            n_fail++; $display("FAIL taint_addr: got %h want %h", sram_addr_o_t0, TAINT ? 32'h0F : 32'h0);
        end
        @(posedge clk_i); #1;
        drive_idle();
        sram_rdata_i = 64'h77; sram_rdata_i_t0 = 64'hFF;
        @(negedge clk_i);
        n_checks++;
        if ({b_rvalid_o, b_rvalid_o_t0, a_rvalid_o_t0} !== {1'b1, TAINT, TAINT}) begin
            n_fail++; $display("FAIL taint_rvalid: got %b want %b", {b_rvalid_o, b_rvalid_o_t0, a_rvalid_o_t0},
                               {1'b1, TAINT, TAINT});
        end
        n_checks++;
        if (b_rdata_o_t0 !== (TAINT ? 64'hFF : 64'h0) || a_rdata_o_t0 !== '0) begin
            n_fail++; $display("FAIL taint_rdata: got b %h a %h want b %h a 0", b_rdata_o_t0, a_rdata_o_t0,
                               TAINT ? 64'hFF : 64'h0);
        end
        @(posedge clk_i); #1;
        a_req_i = 1; a_req_i_t0 = 0; b_req_i_t0 = 1;
        @(negedge clk_i);
        n_checks++;
        if ({a_gnt_o, a_gnt_o_t0, b_gnt_o_t0} !== {1'b1, 1'b0, TAINT}) begin
            n_fail++; $display("FAIL taint_single: got %b want %b", {a_gnt_o, a_gnt_o_t0, b_gnt_o_t0},
                               {1'b1, 1'b0, TAINT});
        end
        @(posedge clk_i); #1;
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_b();
        test_round_robin();
        test_lock();
        test_reset_mid();
        test_taint();
        repeat (2) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
